// File: rtl/qspi_rx_dly_cal.sv
// qspi_rx_dly_cal: QSPI read-data capture stage. Delays every data lane by
// 0..MAX_DLY clocks; the tap comes from the boot strap, a software override or
// an optional calibration sweep.
// Build option: define QSPI_RX_CAL_EN to include the calibration sweep;
// without it the cal outputs are tied low and the cal inputs are ignored.
module qspi_rx_dly_cal #(
  parameter int LANES       = 4,
  parameter int MAX_DLY     = 3,
  parameter int CAL_SAMPLES = 8,
  parameter int SELW        = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] io_in,
  output logic [LANES-1:0] io_out,
  input  logic [SELW-1:0]  boot_dly,
  input  logic             ovr_valid,
  input  logic [SELW-1:0]  ovr_dly,
  output logic [SELW-1:0]  dly_sel,
  input  logic             cal_start,
  input  logic             cal_stb,
  input  logic [LANES-1:0] cal_expect,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail
);

  logic [LANES-1:0] dly_q [1:MAX_DLY];
  logic [LANES-1:0] tap   [0:MAX_DLY];
  logic             strap_done;

  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] v);
    if (int'(v) > MAX_DLY) return SELW'(MAX_DLY);
    return v;
  endfunction

  // Delay line: one register stage per tap beyond tap 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAX_DLY; k++) dly_q[k] <= '0;
    end else begin
      dly_q[1] <= io_in;
      for (int k = 2; k <= MAX_DLY; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  // Tap vector and output mux; tap 0 is the raw pad input.
  always_comb begin
    tap[0] = io_in;
    for (int k = 1; k <= MAX_DLY; k++) tap[k] = dly_q[k];
    io_out = tap[0];
    for (int k = 1; k <= MAX_DLY; k++)
      if (int'(dly_sel) == k) io_out = tap[k];
  end

`ifdef QSPI_RX_CAL_EN
  typedef enum logic {CAL_IDLE, CAL_SWEEP} cal_state_t;

  cal_state_t       cal_state;
  logic [MAX_DLY:0] pass_mask;
  logic [MAX_DLY:0] tap_match;
  logic [MAX_DLY:0] mask_nxt;
  logic [7:0]       cnt;
  logic             last_stb;
  logic [SELW-1:0]  run_mid;

  // Centre of the longest run of passing taps; earliest run wins a tie.
  function automatic logic [SELW-1:0] pick_center(input logic [MAX_DLY:0] m);
    int best_len, best_first, cur_len, cur_first;
    best_len = 0; best_first = 0; cur_len = 0; cur_first = 0;
    for (int i = 0; i <= MAX_DLY; i++) begin
      if (m[i]) begin
        if (cur_len == 0) cur_first = i;
        cur_len++;
        if (cur_len > best_len) begin
          best_len   = cur_len;
          best_first = cur_first;
        end
      end else begin
        cur_len = 0;
      end
    end
    return SELW'(best_first + (best_len - 1) / 2);
  endfunction

  // Compare all taps against the expected nibble and pick the new tap in the same cycle.
  always_comb begin
    tap_match = '0;
    for (int t = 0; t <= MAX_DLY; t++) tap_match[t] = (tap[t] == cal_expect);
    mask_nxt = pass_mask & tap_match;
    last_stb = cal_stb && (cnt == 8'(CAL_SAMPLES - 1));
    run_mid  = pick_center(mask_nxt);
  end
`else
  logic unused_cal;
  assign unused_cal = ^{cal_start, cal_stb, cal_expect, 8'(CAL_SAMPLES)};
  assign cal_busy   = 1'b0;
  assign cal_done   = 1'b0;
  assign cal_fail   = 1'b0;
`endif

  // Tap select: strap once after reset, override (wins over strap), calibration sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_sel    <= '0;
      strap_done <= 1'b0;
`ifdef QSPI_RX_CAL_EN
      cal_state  <= CAL_IDLE;
      pass_mask  <= '0;
      cnt        <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
`endif
    end else begin
      if (!strap_done) begin
        strap_done <= 1'b1;
        dly_sel    <= clamp_sel(boot_dly);
      end
`ifdef QSPI_RX_CAL_EN
      cal_done <= 1'b0;
      case (cal_state)
        CAL_IDLE: begin
          if (ovr_valid) dly_sel <= clamp_sel(ovr_dly);
          if (cal_start && strap_done) begin
            pass_mask <= '1;
            cnt       <= '0;
            cal_fail  <= 1'b0;
            cal_busy  <= 1'b1;
            cal_state <= CAL_SWEEP;
          end
        end
        CAL_SWEEP: begin
          if (cal_stb) begin
            pass_mask <= mask_nxt;
            cnt       <= cnt + 8'd1;
            if (last_stb) begin
              cal_state <= CAL_IDLE;
              cal_busy  <= 1'b0;
              if (|mask_nxt) begin
                dly_sel  <= run_mid;
                cal_done <= 1'b1;
              end else begin
                cal_fail <= 1'b1;
              end
            end
          end
        end
        default: cal_state <= CAL_IDLE;
      endcase
`else
      if (ovr_valid) dly_sel <= clamp_sel(ovr_dly);
`endif
    end
  end

endmodule

// File: doc/qspi_rx_dly_cal.md
# qspi_rx_dly_cal

Parametrised QSPI read-data capture stage between the `uio_in` data pins and the QSPI controller for flash and PSRAM. It delays every data lane by a selectable 0..MAX_DLY clocks to compensate pin-mux and pad latency. The tap is selected by one of three sources:
- boot strap, latched once after reset;
- a software override;
- an optional on-chip calibration sweep against a known read pattern.

## Interface
Parameters:
- `LANES`, 4, number of QSPI data lanes.
- `MAX_DLY`, 3, deepest delay tap in clocks (taps 0..MAX_DLY).
- `CAL_SAMPLES`, 8, matching strobes required per tap during calibration (1..255).
- `SELW`, $clog2(MAX_DLY+1), tap-select width (derived, do not override).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `io_in` in LANES: raw QSPI data from pads.
- `io_out` out LANES: delayed data to controller.
- `boot_dly` in SELW: strap value (`gpio_in[5:4]` at top level).
- `ovr_valid` in 1: one-cycle load strobe for `ovr_dly`.
- `ovr_dly` in SELW: software tap value.
- `dly_sel` out SELW: active tap.
- `cal_start` in 1: one-cycle calibration request.
- `cal_stb` in 1: marks a cycle where the controller expects valid data.
- `cal_expect` in LANES: expected nibble on that cycle.
- `cal_busy` out 1: calibration in progress.
- `cal_done` out 1: one-cycle pulse on successful completion.
- `cal_fail` out 1: sticky until next `cal_start`; no tap passed.

## Operation
- Delay line:
  - Registers `d[1..MAX_DLY]`, each LANES wide; all reset to 0.
  - `d[1]<=io_in` and `d[k]<=d[k-1]` every cycle.
  - Tap 0 is `io_in`.
  - `io_out` is a combinational mux of tap[`dly_sel`].
  - Values of `boot_dly`/`ovr_dly` above MAX_DLY clamp to MAX_DLY.
- Strap latch:
  - `strap_done` resets to 0.
  - On the first rising edge with `rst_n` high, `dly_sel<=boot_dly` (clamped) and `strap_done<=1`.
  - Never re-sampled until the next reset.
- Override: `ovr_valid` loads `dly_sel` next edge. It is ignored while `cal_busy`. It wins over a same-cycle strap latch.
- Calibration FSM: IDLE → SWEEP → IDLE.
  - IDLE + `cal_start` (and `strap_done`): `pass_mask<=all ones`, `cnt<=0`, `cal_fail<=0`, enter SWEEP.
  - SWEEP: each `cal_stb` compares every tap[t] with `cal_expect` in parallel and clears `pass_mask[t]` on mismatch; `cnt++`.
  - When `cnt` reaches CAL_SAMPLES:
    - Choose the longest contiguous run of set bits in `pass_mask`; ties go to the lowest start.
    - Set `dly_sel` to floor((first+last)/2) of that run and pulse `cal_done`.
    - If `pass_mask` is 0, keep `dly_sel` and set `cal_fail`.
    - Return to IDLE in both cases.
  - `cal_start` while SWEEP: ignored.
  - `cal_stb` outside SWEEP: ignored.
  - `dly_sel` is not modified during SWEEP.
- Reset mid-operation: all state returns to reset values immediately (`dly_sel=0`, IDLE, `pass_mask=0`, `cnt=0`). The strap is re-latched after release.

## Timing
- Reset values:
  - `io_out`: tap 0, i.e. follows `io_in`.
  - `dly_sel`, `cal_busy`, `cal_done`, `cal_fail`: all 0.
- Data latency of `io_out` equals `dly_sel` clocks exactly; tap 0 is zero-cycle combinational.
- A `dly_sel` change takes effect on `io_out` in the cycle after the loading edge. There is no glitch filtering; the controller switches taps only while CS is high.
- Calibration:
  - `cal_busy` rises the edge after `cal_start`.
  - `dly_sel` and `cal_done` update one edge after the CAL_SAMPLES-th `cal_stb`, and `cal_busy` falls on that same edge.
  - Minimum duration is CAL_SAMPLES+1 cycles.
- Run selection is combinational over `pass_mask`; for MAX_DLY ≤ 7 it must close in one cycle.

## Configuration
- `QSPI_RX_CAL_EN` defined: calibration FSM, `pass_mask` and `cnt` are built.
- Not defined:
  - Calibration logic is removed.
  - `cal_busy`, `cal_done` and `cal_fail` are tied 0.
  - `cal_start`, `cal_stb` and `cal_expect` are ignored.
  - Only strap and override set `dly_sel`.

## Test plan
- **Strap:** `boot_dly=2`, release reset, drive `io_in` 0x1,0x2,0x3,... → `dly_sel=2`; `io_out` shows 0x1 two cycles after it appears on `io_in`.
- **Clamp and override:** MAX_DLY=2, `boot_dly=3` → `dly_sel=2`. Then `ovr_valid` with `ovr_dly=0` → `io_out==io_in` from the next cycle.
- **Calibration pass:** `io_in` equals `cal_expect` delayed by 2 with a changing pattern, 8 strobes → `pass_mask=0b0100`, `dly_sel=2`, `cal_done` pulses once, `cal_busy` high for 9 cycles.
- **Calibration fail:** `io_in` random, mismatched with `cal_expect` → `cal_fail=1`, `dly_sel` unchanged, `cal_done` stays 0.
- **Reset mid-sweep:** `rst_n` low after 3 strobes → `cal_busy=0` and `dly_sel=0` asynchronously. After release with `boot_dly=1` → `dly_sel=1`.
- **Macro off:** `QSPI_RX_CAL_EN` undefined, pulse `cal_start` plus strobes → all cal outputs 0, `dly_sel` unchanged.
